sw_job_scheduler: RTL
=====================

# sw_job_scheduler

Sequencing controller that sits in front of the Smith-Waterman engine wrapper (`FPGAWrapper`), upstream of its parameter and strobe pins. It queues scoring jobs and issues the reference-load (`set_t`) and calculation-start pulses, applying each job's match, mismatch, −α and −β parameters. It captures each job's result and returns it with its tag, adding a busy-timeout watchdog. It replaces the hand-driven set_t/start/wait(valid)/wait(!busy) sequence with a streaming valid/ready job interface.

## Interface
- `DEPTH`, 4: job FIFO entries (power of two, ≥2).
- `TAG_W`, 4: job tag width.
- `RESULT_W`, `` `V_E_F_Bit ``: engine result width.
- `GUARD`, 2: cycles after a strobe before `i_busy` is trusted.
- `TIMEOUT`, 2^24: maximum cycles spent waiting on the engine before a job is aborted.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_job_valid` in 1, `o_job_ready` out 1: job push handshake.
- `i_job_tag` in TAG_W: job tag.
- `i_job_param` in 16: {match[15:12], mismatch[11:8], minusAlpha[7:4], minusBeta[3:0]}.
- `i_job_load_t` in 1: reload reference before this job.
- `o_set_t`, `o_start_cal` out 1: engine strobes.
- `o_match`, `o_mismatch`, `o_minusAlpha`, `o_minusBeta` out 4 each: engine parameters.
- `i_busy`, `i_valid` in 1: engine status.
- `i_result` in RESULT_W: engine result.
- `o_res_valid` out 1, `i_res_ready` in 1: result handshake.
- `o_res_tag` out TAG_W, `o_res_data` out RESULT_W, `o_res_err` out 1: result payload.
- `o_idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- FIFO entry: {tag, param, load_t}. `o_job_ready` = !full. A push when full is ignored. Push and pop in the same cycle are both legal when not full.
- `t_loaded` flag: cleared by reset and by any timeout error. Set when a SETT_WAIT completes.
- FSM states: IDLE, SETT, SETT_WAIT, LOAD, START, RUN, EMIT.
- IDLE → SETT if the FIFO is non-empty and (head.load_t or !t_loaded).
- IDLE → LOAD if the FIFO is non-empty and no reload is required.
- SETT: `o_set_t`=1 for exactly one cycle → SETT_WAIT.
- SETT_WAIT: count GUARD cycles, then wait for `i_busy`=0, then set `t_loaded` → LOAD.
- LOAD: register head.param onto `o_match`..`o_minusBeta`. The parameters stay stable until the next LOAD. → START.
- START: `o_start_cal`=1 for exactly one cycle → RUN.
- RUN: on the first `i_valid`=1, latch `i_result`; later valids are ignored.
- RUN exit: after GUARD cycles, once `i_busy`=0, pop the FIFO → EMIT.
- RUN error: if `i_busy`=0 and no result has been latched, set err=1 and emit data 0.
- Timeout: a cycle counter runs in SETT_WAIT and RUN. Reaching TIMEOUT pops the head → EMIT with err=1 and data 0, and clears `t_loaded`.
- EMIT: hold `o_res_valid`=1 and a stable payload until `i_res_ready`=1 → IDLE. The FIFO keeps accepting pushes meanwhile.

## Timing
- Reset values: strobes 0, `o_res_valid` 0, params 0, `o_res_*` 0, `o_job_ready` 1, `o_idle` 1. The FIFO is emptied and `t_loaded` is cleared.
- A reset asserted mid-job aborts the job. No result is emitted and no strobe is issued in the following cycle.
- Parameters are valid ≥1 cycle before `o_start_cal` rises and remain stable through `i_busy` falling.
- Latency from an empty FIFO with `t_loaded`=1, push accepted at cycle 0: LOAD at 1, `o_start_cal` at 2, and `o_res_valid` 1 cycle after the RUN exit condition.
- The set_t path adds 1 + GUARD + engine busy time.
- Back-to-back jobs: IDLE is visited for one cycle between EMIT and the next LOAD/SETT.
- `i_valid` and `i_busy`=0 arriving in the same cycle: the result is latched and the exit is taken in that cycle.

## Structure
- Shared package/header `sw_sched_pkg`: FSM state encoding, the param field slice positions and the default GUARD/TIMEOUT constants. Reuse `` `V_E_F_Bit `` from `src/util.v`.
- One sub-module, `sw_job_fifo`: a synchronous FIFO with DEPTH entries, a count-based full/empty and show-ahead head output.

## Test plan
All scenarios use a behavioural engine stub: busy for N cycles after a strobe, then `i_valid` with result = tag+100.
- After reset, push job {tag 1, param 16'h2111, load_t 0}. Expect one `o_set_t` pulse, then one `o_start_cal` pulse with `o_match`=2, `o_mismatch`=1, `o_minusAlpha`=1, `o_minusBeta`=1, then a result with tag 1, data 101 and err 0.
- Push 4 jobs back-to-back (tags 2..5) with the stub at N=10. Expect `o_job_ready`=0 only while 4 are queued, no second `o_set_t`, and results in order 2..5.
- Push a job with load_t=1 while `t_loaded`=1. Expect `o_set_t` to be reissued before `o_start_cal`.
- Hold `i_res_ready`=0 for 20 cycles during EMIT. Expect the payload to stay stable and no new `o_start_cal` until the result is accepted.
- Stub never drops busy, with TIMEOUT=64. Expect err=1 and data 0 for the job, and the next job to reissue `o_set_t`.
- Assert `rst` during RUN. Expect all outputs at reset values the next cycle and no result emitted.

Source files
------------

// File: rtl/sw_sched_pkg.sv
// Shared definitions for the Smith-Waterman job scheduler.
// Holds the FSM state encoding, the job parameter layout (match, mismatch,
// -alpha, -beta nibbles), default guard/timeout constants and the engine
// result width.
package sw_sched_pkg;

    // Engine result width.
    localparam int unsigned VEF_BIT = 16;

    localparam int unsigned FIELD_W         = 4;
    localparam int unsigned PARAM_W         = 4 * FIELD_W;
    localparam int unsigned MATCH_LSB       = 12;
    localparam int unsigned MISMATCH_LSB    = 8;
    localparam int unsigned ALPHA_LSB       = 4;
    localparam int unsigned BETA_LSB        = 0;

    localparam int unsigned DEFAULT_GUARD   = 2;
    localparam int unsigned DEFAULT_TIMEOUT = 32'd1 << 24;

    // Field order mirrors the MATCH/MISMATCH/ALPHA/BETA bit positions above.
    typedef struct packed {
        logic [FIELD_W-1:0] match;
        logic [FIELD_W-1:0] mismatch;
        logic [FIELD_W-1:0] minus_alpha;
        logic [FIELD_W-1:0] minus_beta;
    } sw_param_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETT,
        ST_SETT_WAIT,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_EMIT
    } sched_state_t;

endpackage

// File: rtl/sw_job_fifo.sv
// Synchronous show-ahead FIFO holding queued scoring jobs.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request (ignored when full) and entry
//   pop           : retire the head entry (ignored when empty)
//   rdata         : current head entry, valid whenever !empty
//   full, empty   : occupancy flags derived from the entry count
//   fill          : number of stored entries
module sw_job_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WIDTH  = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [FILL_W-1:0] fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fill <= fill + FILL_W'(push_ok) - FILL_W'(pop_ok);
        end
    end

endmodule

// File: rtl/sw_job_scheduler.sv
// Job sequencer in front of the Smith-Waterman engine wrapper.
// Queues tagged jobs, issues set_t / start_cal strobes with each job's
// scoring parameters, captures the engine result and returns it with the
// job tag. A cycle watchdog aborts jobs whose engine never goes idle.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   i_job_valid/o_job_ready          : job push handshake
//   i_job_tag/i_job_param/i_job_load_t: job payload
//   o_set_t, o_start_cal             : one-cycle engine strobes
//   o_match..o_minusBeta             : engine scoring parameters
//   i_busy, i_valid, i_result        : engine status and result
//   o_res_valid/i_res_ready          : result handshake
//   o_res_tag/o_res_data/o_res_err   : result payload
//   o_idle                           : queue empty and sequencer idle
module sw_job_scheduler
    import sw_sched_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned RESULT_W = VEF_BIT,
    parameter int unsigned GUARD    = DEFAULT_GUARD,
    parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_job_valid,
    output logic                o_job_ready,
    input  logic [TAG_W-1:0]    i_job_tag,
    input  logic [PARAM_W-1:0]  i_job_param,
    input  logic                i_job_load_t,
    output logic                o_set_t,
    output logic                o_start_cal,
    output logic [FIELD_W-1:0]  o_match,
    output logic [FIELD_W-1:0]  o_mismatch,
    output logic [FIELD_W-1:0]  o_minusAlpha,
    output logic [FIELD_W-1:0]  o_minusBeta,
    input  logic                i_busy,
    input  logic                i_valid,
    input  logic [RESULT_W-1:0] i_result,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [TAG_W-1:0]    o_res_tag,
    output logic [RESULT_W-1:0] o_res_data,
    output logic                o_res_err,
    output logic                o_idle
);

    localparam int unsigned ENTRY_W = TAG_W + PARAM_W + 1;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned FILL_W  = $clog2(DEPTH) + 1;

    sched_state_t        state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                t_loaded, t_loaded_n;
    logic                res_latched, res_latched_n;
    logic [RESULT_W-1:0] res_hold, res_hold_n;
    sw_param_t           params, params_n;
    logic [TAG_W-1:0]    res_tag_n;
    logic [RESULT_W-1:0] res_data_n;
    logic                res_err_n;
    logic                pop_c;
    logic [FILL_W-1:0]   fill_n;

    logic [ENTRY_W-1:0]  head_entry;
    logic [TAG_W-1:0]    head_tag;
    sw_param_t           head_param;
    logic                head_load_t;
    logic                full;
    logic                empty;
    logic [FILL_W-1:0]   fill;
    logic                push_ok;
    logic                guard_done;
    logic                timed_out;

    sw_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_job_valid),
        .wdata ({i_job_tag, i_job_param, i_job_load_t}),
        .pop   (pop_c),
        .rdata (head_entry),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    assign {head_tag, head_param, head_load_t} = head_entry;
    assign push_ok    = i_job_valid && !full;
    assign guard_done = (cnt >= CNT_W'(GUARD));
    assign timed_out  = (cnt >= CNT_W'(TIMEOUT - 1));

    assign o_match      = params.match;
    assign o_mismatch   = params.mismatch;
    assign o_minusAlpha = params.minus_alpha;
    assign o_minusBeta  = params.minus_beta;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_n       = state;
        cnt_n         = '0;
        t_loaded_n    = t_loaded;
        res_latched_n = res_latched;
        res_hold_n    = res_hold;
        params_n      = params;
        res_tag_n     = o_res_tag;
        res_data_n    = o_res_data;
        res_err_n     = o_res_err;
        pop_c         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n = (head_load_t || !t_loaded) ? ST_SETT : ST_LOAD;
                end
            end
            ST_SETT: begin
                state_n = ST_SETT_WAIT;
            end
            ST_SETT_WAIT: begin
                if (guard_done && !i_busy) begin
                    t_loaded_n = 1'b1;
                    state_n    = ST_LOAD;
                end else if (timed_out) begin
                    pop_c      = 1'b1;
                    t_loaded_n = 1'b0;
                    res_tag_n  = head_tag;
                    res_data_n = '0;
                    res_err_n  = 1'b1;
                    state_n    = ST_EMIT;
                end
            end
            ST_LOAD: begin
                state_n = ST_START;
            end
            ST_START: begin
                res_latched_n = 1'b0;
                state_n       = ST_RUN;
            end
            ST_RUN: begin
                // Only the first engine valid of a job is kept.
                if (i_valid && !res_latched) begin
                    res_latched_n = 1'b1;
                    res_hold_n    = i_result;
                end
                if (guard_done && !i_busy) begin
                    pop_c     = 1'b1;
                    res_tag_n = head_tag;
                    state_n   = ST_EMIT;
                    if (res_latched) begin
                        res_data_n = res_hold;
                        res_err_n  = 1'b0;
                    end else if (i_valid) begin
                        // Valid and busy-low together still count as a result.
                        res_data_n = i_result;
                        res_err_n  = 1'b0;
                    end else begin
                        res_data_n = '0;
                        res_err_n  = 1'b1;
                    end
                end else if (timed_out) begin
                    pop_c      = 1'b1;
                    t_loaded_n = 1'b0;
                    res_tag_n  = head_tag;
                    res_data_n = '0;
                    res_err_n  = 1'b1;
                    state_n    = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (i_res_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // One counter serves both the guard window and the watchdog.
        if ((state_n == state) && ((state == ST_SETT_WAIT) || (state == ST_RUN))) begin
            cnt_n = cnt + CNT_W'(1);
        end

        // Parameters go out on entry to LOAD so they lead start_cal by a cycle.
        if (state_n == ST_LOAD) begin
            params_n = head_param;
        end

        fill_n = fill + FILL_W'(push_ok) - FILL_W'(pop_c);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            t_loaded    <= 1'b0;
            res_latched <= 1'b0;
            res_hold    <= '0;
            params      <= '0;
            o_set_t     <= 1'b0;
            o_start_cal <= 1'b0;
            o_res_valid <= 1'b0;
            o_res_tag   <= '0;
            o_res_data  <= '0;
            o_res_err   <= 1'b0;
            o_job_ready <= 1'b1;
            o_idle      <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            t_loaded    <= t_loaded_n;
            res_latched <= res_latched_n;
            res_hold    <= res_hold_n;
            params      <= params_n;
            o_set_t     <= (state_n == ST_SETT);
            o_start_cal <= (state_n == ST_START);
            o_res_valid <= (state_n == ST_EMIT);
            o_res_tag   <= res_tag_n;
            o_res_data  <= res_data_n;
            o_res_err   <= res_err_n;
            o_job_ready <= (fill_n != FILL_W'(DEPTH));
            o_idle      <= (state_n == ST_IDLE) && (fill_n == '0);
        end
    end

endmodule
